// File: rtl/mult_ctrl_fsm.sv
// Control FSM for the sequential signed multiplier: synchronises the start button,
// sequences load/shift/done and bounds each run with an iteration counter.
module mult_ctrl_fsm #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EARLY_TERM  = 1,
  localparam int unsigned CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             BTNC,
  input  logic             z_flag_multiplier,
  output logic             shift_en,
  output logic             reg_en,
  output logic             load,
  output logic             psel,
  output logic             led,
  output logic             done_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_q;
  logic                   btn_s;
  logic                   btn_rise;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_pulse_q;

  assign btn_s    = sync_q[SYNC_STAGES-1];
  assign btn_rise = btn_s & ~btn_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (btn_rise) state_d = StLoad;
      StLoad: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        // A restart takes priority and does not count as a shift cycle.
        if (btn_rise) begin
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = StDone;
          end else if ((EARLY_TERM != 0) && z_flag_multiplier) begin
            state_d = StDone;
          end
        end
      end
      StDone: if (btn_rise) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sync_q       <= '0;
      btn_q        <= 1'b0;
      cnt_q        <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], BTNC};
      btn_q        <= btn_s;
      cnt_q        <= cnt_d;
      done_pulse_q <= (state_d == StDone) && (state_q != StDone);
    end
  end

  always_comb begin
    shift_en = 1'b0;
    reg_en   = 1'b0;
    load     = 1'b0;
    psel     = 1'b0;
    led      = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        load   = 1'b1;
        reg_en = 1'b1;
        busy   = 1'b1;
      end
      StRun: begin
        shift_en = 1'b1;
        reg_en   = 1'b1;
        psel     = 1'b1;
        busy     = 1'b1;
      end
      StDone: begin
        led  = 1'b1;
        psel = 1'b1;
      end
      default: ;
    endcase
  end

  assign done_pulse = done_pulse_q;
  assign iter_cnt   = cnt_q;

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Directed bench for mult_ctrl_fsm: three parameterisations share clock, reset and inputs.
module tb_mult_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n;
  logic btnc;
  logic zf;

  always #5 clk = ~clk;

  // dut0: W8/S2/no early term, dut1: W8/S2/early term, dut2: W16/S3/early term
  logic       se0, re0, ld0, ps0, led0, dp0, bz0;
  logic       se1, re1, ld1, ps1, led1, dp1, bz1;
  logic       se2, re2, ld2, ps2, led2, dp2, bz2;
  logic [3:0] cnt0, cnt1;
  logic [4:0] cnt2;

  mult_ctrl_fsm #(.WIDTH(8), .SYNC_STAGES(2), .EARLY_TERM(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .BTNC(btnc), .z_flag_multiplier(zf),
    .shift_en(se0), .reg_en(re0), .load(ld0), .psel(ps0), .led(led0),
    .done_pulse(dp0), .busy(bz0), .iter_cnt(cnt0)
  );

  mult_ctrl_fsm #(.WIDTH(8), .SYNC_STAGES(2), .EARLY_TERM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .BTNC(btnc), .z_flag_multiplier(zf),
    .shift_en(se1), .reg_en(re1), .load(ld1), .psel(ps1), .led(led1),
    .done_pulse(dp1), .busy(bz1), .iter_cnt(cnt1)
  );

  mult_ctrl_fsm #(.WIDTH(16), .SYNC_STAGES(3), .EARLY_TERM(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .BTNC(btnc), .z_flag_multiplier(zf),
    .shift_en(se2), .reg_en(re2), .load(ld2), .psel(ps2), .led(led2),
    .done_pulse(dp2), .busy(bz2), .iter_cnt(cnt2)
  );

  // Output vector: {load, shift_en, reg_en, psel, led, done_pulse, busy}
  function automatic logic [6:0] outv(input int d);
    case (d)
      0:       return {ld0, se0, re0, ps0, led0, dp0, bz0};
      1:       return {ld1, se1, re1, ps1, led1, dp1, bz1};
      default: return {ld2, se2, re2, ps2, led2, dp2, bz2};
    endcase
  endfunction

  function automatic int cnt(input int d);
    case (d)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    btnc  = 1'b0;
    zf    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic press;
    btnc = 1'b1;
    tick();
    btnc = 1'b0;
  endtask

  task automatic run_count(input int d, input int cycles,
                           output int nload, output int nshift, output int ndp);
    logic [6:0] v;
    nload  = 0;
    nshift = 0;
    ndp    = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      v = outv(d);
      nload  += int'(v[6]);
      nshift += int'(v[5]);
      ndp    += int'(v[1]);
    end
  endtask

  // Bounded wait for load on dut d; found=0 if the budget expired.
  task automatic wait_load(input int d, input int budget, output int found);
    logic [6:0] v;
    found = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      tick();
      v = outv(d);
      if (v[6]) found = 1;
    end
  endtask

  typedef struct {
    logic       btnc;
    logic       z;
    logic [6:0] vec;
    int         cnt;
  } vec_t;

  vec_t tab[9];

  initial begin
    int nl, ns, nd, nl2, ns2, nd2, found, lat0, lat2;
    logic [6:0] acc;
    logic [6:0] v;

    // Early-termination sequence on dut1: z rises in the 3rd RUN cycle.
    tab[0] = '{1'b1, 1'b0, 7'b0000000, 0};
    tab[1] = '{1'b1, 1'b0, 7'b0000000, 0};
    tab[2] = '{1'b0, 1'b0, 7'b1010001, 0};
    tab[3] = '{1'b0, 1'b0, 7'b0111001, 0};
    tab[4] = '{1'b0, 1'b0, 7'b0111001, 1};
    tab[5] = '{1'b0, 1'b0, 7'b0111001, 2};
    tab[6] = '{1'b0, 1'b1, 7'b0001110, 3};
    tab[7] = '{1'b0, 1'b0, 7'b0001100, 3};
    tab[8] = '{1'b0, 1'b1, 7'b0001100, 3};

    rst_n = 1'b0;
    btnc  = 1'b0;
    zf    = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_out%0d", d), int'(outv(d)), 0);
      check($sformatf("reset_cnt%0d", d), cnt(d), 0);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      btnc = tab[i].btnc;
      zf   = tab[i].z;
      tick();
      check($sformatf("tab_vec[%0d]", i), int'(outv(1)), int'(tab[i].vec));
      check($sformatf("tab_cnt[%0d]", i), cnt(1), tab[i].cnt);
    end

    // Full run, z held low.
    do_reset();
    press();
    run_count(0, 30, nl, ns, nd);
    check("full_load_cycles", nl, 1);
    check("full_shift_cycles", ns, 8);
    check("full_done_pulses", nd, 1);
    check("full_led", int'(led0), 1);
    check("full_cnt0", cnt(0), 8);
    check("full_cnt1_no_z", cnt(1), 8);

    // z already high in the first RUN cycle.
    do_reset();
    zf = 1'b1;
    press();
    run_count(1, 30, nl, ns, nd);
    check("zfirst_cnt1", cnt(1), 1);
    check("zfirst_shift1", ns, 1);
    check("zfirst_cnt0_ignores_z", cnt(0), 8);
    zf = 1'b0;

    // Button held for 50 cycles.
    do_reset();
    btnc = 1'b1;
    run_count(0, 50, nl, ns, nd);
    btnc = 1'b0;
    run_count(0, 20, nl2, ns2, nd2);
    check("held_load_cycles", nl + nl2, 1);
    check("held_shift_cycles", ns + ns2, 8);
    check("held_cnt", cnt(0), 8);

    // Restart during RUN cycle 4.
    do_reset();
    press();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (se0 && cnt0 == 4'd3) found = 1;
    end
    check("restart_reach_run4", found, 1);
    press();
    wait_load(0, 10, found);
    check("restart_load_seen", found, 1);
    tick();
    check("restart_cnt_cleared", cnt(0), 0);
    check("restart_first_shift", int'(se0), 1);
    run_count(0, 25, nl, ns, nd);
    check("restart_rest_shifts", ns, 7);
    check("restart_done_pulses", nd, 1);
    check("restart_cnt", cnt(0), 8);

    // Press in DONE starts a new run and drops led on LOAD.
    press();
    wait_load(0, 10, found);
    check("done_press_load_seen", found, 1);
    check("done_press_led", int'(led0), 0);
    check("done_press_busy", int'(bz0), 1);

    // Latency and WIDTH=16 run: BTNC rises between edges.
    do_reset();
    @(posedge clk);
    #3;
    btnc = 1'b1;
    lat0 = -1;
    lat2 = -1;
    ns   = 0;
    nd   = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (ld0 && lat0 < 0) lat0 = n;
      if (ld2 && lat2 < 0) lat2 = n;
      ns += int'(se2);
      nd += int'(dp2);
    end
    btnc = 1'b0;
    check("latency_sync2", lat0, 3);
    check("latency_sync3", lat2, 4);
    check("w16_shift_cycles", ns, 16);
    check("w16_done_pulses", nd, 1);
    check("w16_cnt", cnt(2), 16);
    check("w16_led", int'(led2), 1);

    // Asynchronous reset in the middle of a run.
    do_reset();
    press();
    repeat (5) tick();
    check("pre_reset_busy", int'(bz0), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_out0", int'(outv(0)), 0);
    check("async_reset_cnt0", cnt(0), 0);
    check("async_reset_out2", int'(outv(2)), 0);
    tick();
    rst_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        v = outv(d);
        acc |= v;
      end
    end
    check("idle_after_reset", int'(acc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
